// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter (and future receiver):
// FSM state encodings, parity mode codes, divisor floor and parity helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MIN_DIV       = 2;
    localparam int unsigned MAX_DATA_BITS = 9;

    // Mode 2'b11 is an alias for "no parity".
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode != PAR_NONE) && (mode != 2'b11);
    endfunction

    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..D-1 and flags the last cycle of each bit.
// Synchronous restart aligns the count with a frame start.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Enable,
    input  logic                 i_Restart,
    input  logic [DIV_WIDTH-1:0] i_Div,
    output logic                 o_Bit_Tick
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_last;

    // i_Div is always >= MIN_DIV, so the subtraction cannot underflow.
    assign w_last     = (r_cnt == (i_Div - DIV_WIDTH'(1)));
    assign o_Bit_Tick = i_Enable && w_last;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_cnt <= '0;
        end else if (i_Restart || !i_Enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with one-entry holding buffer and runtime divisor.
// Optional parity bit and i_Parity_Mode port are enabled by UART_TX_PARITY_EN.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]           i_Parity_Mode,
`endif
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    state_t               r_state,    w_state_nxt;
    logic [DATA_BITS-1:0] r_buf,      w_buf_nxt;
    logic                 r_buf_full, w_buf_full_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [IDX_W-1:0]     r_bit_idx,  w_bit_idx_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    logic [DIV_WIDTH-1:0] r_div,      w_div_nxt;
    logic                 r_serial,   w_serial_nxt;
    logic                 r_active,   w_active_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_ready,    w_ready_nxt;
`ifdef UART_TX_PARITY_EN
    logic [1:0]           r_par_mode, w_par_mode_nxt;
    logic                 r_parity,   w_parity_nxt;
`endif

    logic                 w_accept;
    logic                 w_load;
    logic                 w_bypass;
    logic                 w_restart;
    logic                 w_bit_tick;
    logic [DATA_BITS-1:0] w_load_byte;
    logic [DIV_WIDTH-1:0] w_div_in;

    assign w_accept = i_Tx_DV && r_ready;
    assign w_div_in = (i_Clks_Per_Bit < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV)
                                                             : i_Clks_Per_Bit;

    uart_baud_cnt #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_cnt (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Enable   (r_state != S_IDLE),
        .i_Restart  (w_restart),
        .i_Div      (r_div),
        .o_Bit_Tick (w_bit_tick)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_div_nxt      = r_div;
        w_serial_nxt   = r_serial;
        w_active_nxt   = r_active;
        w_done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_mode_nxt = r_par_mode;
        w_parity_nxt   = r_parity;
`endif
        w_load         = 1'b0;
        w_bypass       = 1'b0;
        w_restart      = 1'b0;
        w_load_byte    = r_buf_full ? r_buf : i_Tx_Byte;

        case (r_state)
            S_IDLE: begin
                w_serial_nxt = 1'b1;
                w_active_nxt = 1'b0;
                // An accept while idle and empty feeds the shifter directly,
                // so the start bit appears the cycle after the accept.
                if (r_buf_full || w_accept) begin
                    w_load   = 1'b1;
                    w_bypass = !r_buf_full;
                end
            end
            S_START: begin
                if (w_bit_tick) begin
                    w_state_nxt   = S_DATA;
                    w_serial_nxt  = r_shift[0];
                    w_bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (parity_on(r_par_mode)) begin
                            w_state_nxt  = S_PARITY;
                            w_serial_nxt = r_parity;
                        end else
`endif
                        begin
                            w_state_nxt    = S_STOP;
                            w_serial_nxt   = 1'b1;
                            w_stop_idx_nxt = 1'b0;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                        w_serial_nxt  = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_state_nxt    = S_STOP;
                    w_serial_nxt   = 1'b1;
                    w_stop_idx_nxt = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_tick) begin
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_done_nxt = 1'b1;
                        if (r_buf_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_active_nxt = 1'b0;
                        end
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_serial_nxt = 1'b1;
                w_active_nxt = 1'b0;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = S_START;
            w_shift_nxt    = w_load_byte;
            w_div_nxt      = w_div_in;
            w_serial_nxt   = 1'b0;
            w_active_nxt   = 1'b1;
            w_restart      = 1'b1;
            w_bit_idx_nxt  = '0;
            w_stop_idx_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_par_mode_nxt = i_Parity_Mode;
            w_parity_nxt   = parity_bit(MAX_DATA_BITS'(w_load_byte), i_Parity_Mode);
`endif
        end

        // Drain first, then refill: a same-cycle accept keeps the buffer full.
        if (w_load && r_buf_full) begin
            w_buf_full_nxt = 1'b0;
        end
        if (w_accept && !w_bypass) begin
            w_buf_nxt      = i_Tx_Byte;
            w_buf_full_nxt = 1'b1;
        end
        w_ready_nxt = !w_buf_full_nxt;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_div      <= DIV_WIDTH'(MIN_DIV);
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par_mode <= PAR_NONE;
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_div      <= w_div_nxt;
            r_serial   <= w_serial_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
            r_ready    <= w_ready_nxt;
`ifdef UART_TX_PARITY_EN
            r_par_mode <= w_par_mode_nxt;
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    assign o_Tx_Ready  = r_ready;
    assign o_Tx_Active = r_active;
    assign o_Tx_Serial = r_serial;
    assign o_Tx_Done   = r_done;

endmodule
